// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encoding, default sizing and parity modes.
// Imported by both the transmitter and the receiver.
package uart_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TIME       = 16;
    localparam bit PAR_EVEN       = 1'b0;
    localparam bit PAR_ODD        = 1'b1;

    // Word is zero-extended to 9 bits so one helper serves every DATA_WIDTH.
    function automatic logic parity_bit(input logic [8:0] w, input bit odd);
        return (^w) ^ odd;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1..2 stop bits.
// Bit timing comes from the shared oversampling strobe s_tick (TIME per bit).
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIME       = DEF_TIME,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_tick,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_in,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick
);

    localparam int TW = $clog2(TIME);
    localparam int BW = $clog2(DATA_WIDTH) + 1;

    uart_state_e           r_state, w_state_n;
    logic [TW-1:0]         r_tick, w_tick_n;
    logic [BW-1:0]         r_bit, w_bit_n;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_n;
    logic                  r_par, w_par_n;
    logic                  r_tx, w_tx_n;
    logic                  r_busy;
    logic                  r_done, w_done_n;
    logic                  w_last;

    assign w_last = s_tick && (r_tick == TW'(TIME - 1));

    always_comb begin
        w_state_n = r_state;
        w_tick_n  = r_tick;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        w_done_n  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (tx_start) begin
                    w_shift_n = tx_in;
                    w_par_n   = parity_bit(9'(tx_in), PARITY_ODD != 0);
                    w_tick_n  = '0;
                    w_state_n = ST_START;
                end
            end
            ST_START: begin
                if (w_last) begin
                    w_tick_n  = '0;
                    w_bit_n   = '0;
                    w_state_n = ST_DATA;
                end else if (s_tick) begin
                    w_tick_n = r_tick + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_last) begin
                    w_shift_n = r_shift >> 1;
                    w_tick_n  = '0;
                    if (r_bit == BW'(DATA_WIDTH - 1)) begin
                        // Stop bits are counted from zero in STOP.
                        w_bit_n   = '0;
                        w_state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_n = r_bit + 1'b1;
                    end
                end else if (s_tick) begin
                    w_tick_n = r_tick + 1'b1;
                end
            end
            ST_PARITY: begin
                if (w_last) begin
                    w_tick_n  = '0;
                    w_bit_n   = '0;
                    w_state_n = ST_STOP;
                end else if (s_tick) begin
                    w_tick_n = r_tick + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_last) begin
                    w_tick_n = '0;
                    if (r_bit == BW'(STOP_BITS - 1)) begin
                        w_state_n = ST_IDLE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_bit_n = r_bit + 1'b1;
                    end
                end else if (s_tick) begin
                    w_tick_n = r_tick + 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Line level is registered from the next state so tx is glitch-free.
    always_comb begin
        w_tx_n = 1'b1;
        unique case (w_state_n)
            ST_START:  w_tx_n = 1'b0;
            ST_DATA:   w_tx_n = w_shift_n[0];
            ST_PARITY: w_tx_n = w_par_n;
            default:   w_tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_tick  <= w_tick_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_par   <= w_par_n;
            r_tx    <= w_tx_n;
            r_busy  <= (w_state_n != ST_IDLE);
            r_done  <= w_done_n;
        end
    end

    assign tx           = r_tx;
    assign tx_busy      = r_busy;
    assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: three parameter sets share one
// stimulus stream and are compared every clock against a frame-level model.
module tb_uart_transmitter;

    localparam int TIME = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_in = 8'h00;
    logic [2:0] w_tx, w_busy, w_done;

    always #5 clk = ~clk;

    uart_transmitter #(.DATA_WIDTH(8), .TIME(TIME), .PARITY_EN(0),
                       .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
        .clk(clk), .reset(reset_n), .s_tick(s_tick), .tx_start(tx_start),
        .tx_in(tx_in), .tx(w_tx[0]), .tx_busy(w_busy[0]),
        .tx_done_tick(w_done[0]));

    uart_transmitter #(.DATA_WIDTH(8), .TIME(TIME), .PARITY_EN(1),
                       .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
        .clk(clk), .reset(reset_n), .s_tick(s_tick), .tx_start(tx_start),
        .tx_in(tx_in), .tx(w_tx[1]), .tx_busy(w_busy[1]),
        .tx_done_tick(w_done[1]));

    uart_transmitter #(.DATA_WIDTH(8), .TIME(TIME), .PARITY_EN(1),
                       .PARITY_ODD(1), .STOP_BITS(2)) u_d2 (
        .clk(clk), .reset(reset_n), .s_tick(s_tick), .tx_start(tx_start),
        .tx_in(tx_in), .tx(w_tx[2]), .tx_busy(w_busy[2]),
        .tx_done_tick(w_done[2]));

    typedef struct {
        logic [7:0] w;
        logic [9:0] fa;
        logic       pe;
    } vec_t;

    vec_t tbl[8];

    int checks = 0;
    int failures = 0;
    int gcyc = 0;

    // Reference model: each frame is a list of line levels, one per bit
    // period; n counts s_ticks since the start bit began.
    logic [15:0] m_bits[3];
    int          m_len[3];
    int          m_n[3];
    bit          m_act[3];
    bit          m_done[3];
    int          done_cnt[3];

    logic [7:0] cur_w;
    logic [9:0] cur_fa;
    logic       cur_pe;

    function automatic logic [15:0] mk(int d);
        if (d == 0) return {6'b0, cur_fa};
        if (d == 1) return {5'b0, 1'b1, cur_pe, cur_w, 1'b0};
        return {4'b0, 2'b11, ~cur_pe, cur_w, 1'b0};
    endfunction

    task automatic set_word(input logic [7:0] w, input logic [9:0] fa,
                            input logic pe);
        tx_in  = w;
        cur_w  = w;
        cur_fa = fa;
        cur_pe = pe;
    endtask

    task automatic set_rand_word(input logic [7:0] w);
        set_word(w, {1'b1, w, 1'b0}, ^w);
    endtask

    task automatic chk(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s {tx,busy,done} got=%b exp=%b", name, act, exp);
        end
    endtask

    task automatic step(input bit st, input bit start);
        bit   was;
        logic etx;
        s_tick   = st;
        tx_start = start;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            was       = m_act[d];
            m_done[d] = 1'b0;
            if (!reset_n) begin
                m_act[d] = 1'b0;
                m_n[d]   = 0;
            end else begin
                if (was && st) begin
                    m_n[d]++;
                    if (m_n[d] == m_len[d] * TIME) begin
                        m_act[d]  = 1'b0;
                        m_done[d] = 1'b1;
                    end
                end
                if (!was && start) begin
                    m_act[d]  = 1'b1;
                    m_n[d]    = 0;
                    m_bits[d] = mk(d);
                end
            end
        end
        gcyc++;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            etx = m_act[d] ? m_bits[d][m_n[d] / TIME] : 1'b1;
            if (w_done[d] === 1'b1) done_cnt[d]++;
            chk($sformatf("dut%0d_cyc%0d", d, gcyc),
                {w_tx[d], w_busy[d], w_done[d]},
                {etx, m_act[d], m_done[d]});
        end
    endtask

    function automatic bit tick_now();
        return (gcyc % 4) == 3;
    endfunction

    task automatic run(input int n, input bit start);
        for (int i = 0; i < n; i++) step(tick_now(), start);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((m_act[0] || m_act[1] || m_act[2]) && i < 4000) begin
            step(tick_now(), 1'b0);
            i++;
        end
        checks++;
        if (i >= 4000) begin
            failures++;
            $display("FAIL %s_timeout got=busy exp=idle", name);
        end
        run(3, 1'b0);
    endtask

    task automatic chk_done(input string name, input int d, input int exp);
        checks++;
        if (done_cnt[d] != exp) begin
            failures++;
            $display("FAIL %s done_pulses got=%0d exp=%0d", name,
                     done_cnt[d], exp);
        end
    endtask

    initial begin
        tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
        tbl[1] = '{8'h07, 10'b1000001110, 1'b1};
        tbl[2] = '{8'h3C, 10'b1001111000, 1'b0};
        tbl[3] = '{8'h81, 10'b1100000010, 1'b0};
        tbl[4] = '{8'hFF, 10'b1111111110, 1'b0};
        tbl[5] = '{8'h00, 10'b1000000000, 1'b0};
        tbl[6] = '{8'h80, 10'b1100000000, 1'b1};
        tbl[7] = '{8'h5A, 10'b1010110100, 1'b0};
        m_len[0] = 10;
        m_len[1] = 11;
        m_len[2] = 12;
        for (int d = 0; d < 3; d++) begin
            m_act[d] = 1'b0;
            m_n[d] = 0;
            m_done[d] = 1'b0;
            m_bits[d] = '0;
            done_cnt[d] = 0;
        end
        set_word(8'h00, 10'b1000000000, 1'b0);

        // Reset state, with a start request that reset must override.
        reset_n = 1'b0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        reset_n = 1'b1;
        run(4, 1'b0);

        // Table of single frames.
        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < 3; d++) done_cnt[d] = 0;
            set_word(tbl[k].w, tbl[k].fa, tbl[k].pe);
            step(tick_now(), 1'b1);
            drain($sformatf("tbl%0d", k));
            chk_done($sformatf("tbl%0d_d0", k), 0, 1);
            chk_done($sformatf("tbl%0d_d2", k), 2, 1);
        end

        // Second start mid-DATA with a different word is ignored.
        for (int d = 0; d < 3; d++) done_cnt[d] = 0;
        set_word(tbl[0].w, tbl[0].fa, tbl[0].pe);
        step(tick_now(), 1'b1);
        while (m_n[0] < 3 * TIME + 5) step(tick_now(), 1'b0);
        set_word(tbl[4].w, tbl[4].fa, tbl[4].pe);
        step(tick_now(), 1'b1);
        step(tick_now(), 1'b1);
        drain("ignore_start");
        chk_done("ignore_start", 0, 1);

        // Start held high: back-to-back frames with a 1-clk gap.
        for (int d = 0; d < 3; d++) done_cnt[d] = 0;
        set_word(tbl[2].w, tbl[2].fa, tbl[2].pe);
        run(12 * TIME * 4 * 3 + 20, 1'b1);
        drain("b2b");
        chk_done("b2b_d0", 0, 4);

        // Reset during data bit 4 aborts the frame; a new frame follows.
        for (int d = 0; d < 3; d++) done_cnt[d] = 0;
        set_word(tbl[3].w, tbl[3].fa, tbl[3].pe);
        step(tick_now(), 1'b1);
        while (m_n[0] < 5 * TIME + 3) step(tick_now(), 1'b0);
        reset_n = 1'b0;
        step(tick_now(), 1'b0);
        reset_n = 1'b1;
        run(40, 1'b0);
        chk_done("abort", 0, 0);
        step(tick_now(), 1'b1);
        drain("after_abort");
        chk_done("after_abort", 0, 1);

        // s_tick stalled for 100 clks inside the start bit.
        set_word(tbl[7].w, tbl[7].fa, tbl[7].pe);
        step(tick_now(), 1'b1);
        while (m_n[0] < 6) step(tick_now(), 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
        drain("stall");

        // Randomized traffic: random words, starts, tick spacing, resets.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 7) == 0) set_rand_word(8'($urandom));
            reset_n = ($urandom_range(0, 1499) != 0);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end
        reset_n = 1'b1;
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
